// File: rtl/multi_tick_gen_pkg.sv
// Shared definitions for the multi-channel tick generator: channel mode
// encoding and the decode of the raw 2-bit mode field written by software.
package multi_tick_gen_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10
  } mode_t;

  // The reserved encoding 2'b11 collapses to OFF so it can never run a channel.
  function automatic mode_t decodeMode(input logic [1:0] rawMode);
    case (rawMode)
      2'b01:   return MODE_PERIODIC;
      2'b10:   return MODE_ONESHOT;
      default: return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/multi_tick_gen_channel.sv
// One tick channel: a down-counter reloaded from its divisor, plus the mode
// register that decides whether the channel free-runs, fires once, or idles.
module tick_gen_channel
  import multi_tick_gen_pkg::*;
#(
  parameter int N_BIT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [N_BIT-1:0] i_loadDiv,
  input  logic [1:0]       i_loadMode,
  input  logic             i_restart,
  output logic             o_tick,
  output logic             o_tickNext,
  output logic             o_active
);

  logic [N_BIT-1:0] r_count;
  logic [N_BIT-1:0] r_div;
  mode_t            r_mode;
  logic             r_tick;
  logic             r_active;

  logic [N_BIT-1:0] w_countNext;
  logic [N_BIT-1:0] w_divNext;
  mode_t            w_modeNext;
  logic             w_tickNext;
  logic             w_activeNext;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_div    <= '0;
      r_mode   <= MODE_OFF;
      r_tick   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_count  <= w_countNext;
      r_div    <= w_divNext;
      r_mode   <= w_modeNext;
      r_tick   <= w_tickNext;
      r_active <= w_activeNext;
    end
  end

  // A load beats a restart, and both beat counting; any of them drops the tick.
  always_comb begin
    w_countNext = r_count;
    w_divNext   = r_div;
    w_modeNext  = r_mode;
    w_tickNext  = 1'b0;
    if (i_load) begin
      w_divNext   = i_loadDiv;
      w_modeNext  = decodeMode(i_loadMode);
      w_countNext = i_loadDiv;
    end else if (r_mode != MODE_OFF) begin
      if (i_restart) begin
        w_countNext = r_div;
      end else if (i_enable) begin
        if (r_count == '0) begin
          w_tickNext = 1'b1;
          if (r_mode == MODE_PERIODIC) begin
            w_countNext = r_div;
          end else begin
            w_modeNext = MODE_OFF;
          end
        end else begin
          w_countNext = r_count - N_BIT'(1);
        end
      end
    end
    w_activeNext = (w_modeNext != MODE_OFF);
  end

  always_comb begin
    o_tick     = r_tick;
    o_tickNext = w_tickNext;
    o_active   = r_active;
  end

endmodule

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: decodes configuration writes to
// per-channel counters and merges their ticks into a single aligned strobe.
module multi_tick_gen
  import multi_tick_gen_pkg::*;
#(
  parameter int N_BIT    = 16,
  parameter int CHANNELS = 4,
  parameter int CH_BIT   = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cfg_wr,
  input  logic [CH_BIT-1:0]   cfg_chan,
  input  logic [N_BIT-1:0]    cfg_div,
  input  logic [1:0]          cfg_mode,
  input  logic                sync_restart,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] active,
  output logic                tick_any
);

  logic                w_chanValid;
  logic [CHANNELS-1:0] w_load;
  logic [CHANNELS-1:0] w_tickNext;
  logic                r_tickAny;

  // Channel numbers past the last built channel address nothing at all.
  assign w_chanValid = (32'(cfg_chan) < CHANNELS);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_load[gi] = cfg_wr && w_chanValid && (cfg_chan == CH_BIT'(gi));

      tick_gen_channel #(
        .N_BIT(N_BIT)
      ) u_chan (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_enable   (enable),
        .i_load     (w_load[gi]),
        .i_loadDiv  (cfg_div),
        .i_loadMode (cfg_mode),
        .i_restart  (sync_restart),
        .o_tick     (tick[gi]),
        .o_tickNext (w_tickNext[gi]),
        .o_active   (active[gi])
      );
    end
  endgenerate

  // Built from the channels' next-state ticks so it lands on the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_tickAny <= 1'b0;
    end else begin
      r_tickAny <= |w_tickNext;
    end
  end

  assign tick_any = r_tickAny;

endmodule

// File: tb/tb_multi_tick_gen.sv
// Bench for multi_tick_gen: a 4-channel and a 3-channel build share stimulus
// and are compared each cycle against an elapsed-edge reference model.
module tb_multi_tick_gen;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_chan = 2'd0;
  logic [15:0] cfg_div = 16'd0;
  logic [1:0]  cfg_mode = 2'd0;
  logic        sync_restart = 1'b0;

  logic [3:0] tickA, activeA;
  logic       anyA;
  logic [2:0] tickB, activeB;
  logic       anyB;

  int checks = 0;
  int errors = 0;

  // Model state per build (0 = four channels, 1 = three channels).
  longint     mDiv[2][4];
  int         mMode[2][4];
  longint     mElap[2][4];
  logic [3:0] mTick[2];
  int         nch[2] = '{4, 3};

  always #5 clock = ~clock;

  multi_tick_gen #(.N_BIT(16), .CHANNELS(4), .CH_BIT(2)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .sync_restart(sync_restart), .tick(tickA), .active(activeA), .tick_any(anyA)
  );

  multi_tick_gen #(.N_BIT(16), .CHANNELS(3), .CH_BIT(2)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .sync_restart(sync_restart), .tick(tickB), .active(activeB), .tick_any(anyB)
  );

  // A channel ticks when its count of enabled edges since load/restart reaches
  // a multiple of N+1 (periodic) or exactly N+1 (one-shot).
  task automatic modelEdge();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < 4; c++) begin
        logic t;
        t = 1'b0;
        if (!reset_n) begin
          mDiv[u][c] = 0; mMode[u][c] = 0; mElap[u][c] = 0;
        end else if (cfg_wr && int'(cfg_chan) == c && c < nch[u]) begin
          mDiv[u][c]  = longint'(cfg_div);
          mMode[u][c] = (cfg_mode == 2'd1 || cfg_mode == 2'd2) ? int'(cfg_mode) : 0;
          mElap[u][c] = 0;
        end else if (mMode[u][c] != 0 && sync_restart) begin
          mElap[u][c] = 0;
        end else if (mMode[u][c] != 0 && enable) begin
          mElap[u][c]++;
          if (mMode[u][c] == 1 && (mElap[u][c] % (mDiv[u][c] + 1)) == 0) begin
            t = 1'b1;
          end else if (mMode[u][c] == 2 && mElap[u][c] == mDiv[u][c] + 1) begin
            t = 1'b1;
            mMode[u][c] = 0;
          end
        end
        mTick[u][c] = t;
      end
    end
  endtask

  function automatic logic [3:0] modelActive(input int u);
    logic [3:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c] = (mMode[u][c] != 0);
    return v;
  endfunction

  task automatic tickClock();
    @(posedge clock);
    modelEdge();
    #1;
    cfg_wr = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic setWrite(input int ch, input int div, input logic [1:0] mode);
    cfg_wr = 1'b1;
    cfg_chan = 2'(ch);
    cfg_div = 16'(div);
    cfg_mode = mode;
  endtask

  task automatic test_reset();
    logic [3:0] eB, eT;
    for (int i = 0; i < 3; i++) begin
      reset_n = 1'b0; enable = 1'b1; sync_restart = 1'b1;
      setWrite(i, 2, 2'b01);
      tickClock();
      eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== 9'd0 || {tickA, activeA, anyA} !== {mTick[0], modelActive(0), |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL reset4 cyc %0d: got tick=%b active=%b any=%b, want all zero", i, tickA, activeA, anyA);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT} || {tickB, activeB, anyB} !== 7'd0) begin
        errors++;
        $display("[TB] FAIL reset3 cyc %0d: got tick=%b active=%b any=%b, want all zero", i, tickB, activeB, anyB);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_periodic();
    logic [3:0] eA, eB, eT;
    enable = 1'b1;
    setWrite(0, 3, 2'b01);
    for (int i = 0; i <= 12; i++) begin
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL periodic4 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL periodic3 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
      checks++;
      if (tickA[0] !== (i > 0 && i % 4 == 0) || anyA !== tickA[0] || activeA !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL periodic_n3 cyc %0d: got tick0=%b any=%b active=%b", i, tickA[0], anyA, activeA);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [3:0] eA, eB, eT;
    int ones;
    ones = 0;
    setWrite(1, 2, 2'b10);
    for (int i = 0; i <= 22; i++) begin
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      if (tickA[1] === 1'b1) ones++;
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL oneshot4 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL oneshot3 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
      checks++;
      if (tickA[1] !== (i == 3) || activeA[1] !== (i < 3)) begin
        errors++;
        $display("[TB] FAIL oneshot_n2 cyc %0d: got tick1=%b active1=%b", i, tickA[1], activeA[1]);
      end
    end
    checks++;
    if (ones != 1) begin
      errors++;
      $display("[TB] FAIL oneshot_count: got %0d ticks, want 1", ones);
    end
  endtask

  task automatic test_enable_gap();
    logic [3:0] eA, eB, eT;
    setWrite(0, 4, 2'b01);
    for (int i = 0; i <= 20; i++) begin
      enable = !(i >= 2 && i <= 4);
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL enable4 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL enable3 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
      checks++;
      if (tickA[0] !== (i == 8 || i == 13 || i == 18)) begin
        errors++;
        $display("[TB] FAIL enable_gap cyc %0d: got tick0=%b", i, tickA[0]);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_sync_restart();
    logic [3:0] eA, eB, eT;
    setWrite(0, 5, 2'b01);
    tickClock();
    tickClock();
    setWrite(2, 5, 2'b01);
    tickClock();
    tickClock();
    sync_restart = 1'b1;
    tickClock();
    for (int j = 1; j <= 18; j++) begin
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL restart4 cyc %0d: got %b/%b/%b want %b/%b/%b", j, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL restart3 cyc %0d: got %b/%b/%b want %b/%b/%b", j, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
      checks++;
      if (tickA[0] !== (j % 6 == 0) || tickA[2] !== (j % 6 == 0)) begin
        errors++;
        $display("[TB] FAIL restart_align cyc %0d: got tick0=%b tick2=%b", j, tickA[0], tickA[2]);
      end
    end
  endtask

  task automatic test_invalid_write();
    logic [3:0] eA, eB, eT;
    setWrite(3, 7, 2'b01);
    sync_restart = 1'b1;
    tickClock();
    for (int j = 1; j <= 28; j++) begin
      if (j == 17) setWrite(3, 1, 2'b10);
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL wr_restart4 cyc %0d: got %b/%b/%b want %b/%b/%b", j, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL wr_restart3 cyc %0d: got %b/%b/%b want %b/%b/%b", j, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
      checks++;
      if (tickA[3] !== ((j <= 16) ? (j % 8 == 0) : (j == 19)) || activeA[3] !== (j < 19)) begin
        errors++;
        $display("[TB] FAIL ch3_write cyc %0d: got tick3=%b active3=%b", j, tickA[3], activeA[3]);
      end
      checks++;
      if (activeB !== 3'b101 || tickB[0] !== (j % 6 == 0) || tickB[2] !== (j % 6 == 0)) begin
        errors++;
        $display("[TB] FAIL invalid_chan cyc %0d: got active=%b tick=%b", j, activeB, tickB);
      end
    end
  endtask

  task automatic test_zero_div_and_reset();
    logic [3:0] eA, eB, eT;
    setWrite(0, 0, 2'b01);
    for (int i = 0; i <= 12; i++) begin
      reset_n = (i != 6);
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL zero4 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL zero3 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
      checks++;
      if ((i >= 1 && i <= 5 && (tickA[0] !== 1'b1 || anyA !== 1'b1)) ||
          (i >= 6 && {tickA, activeA, anyA} !== 9'd0)) begin
        errors++;
        $display("[TB] FAIL zero_then_reset cyc %0d: got tick=%b active=%b any=%b", i, tickA, activeA, anyA);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] eA, eB, eT;
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 15) begin
        cfg_wr = 1'b1;
        cfg_chan = 2'($urandom_range(0, 3));
        cfg_div = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 9));
        cfg_mode = 2'($urandom_range(0, 3));
      end
      sync_restart = ($urandom_range(0, 99) < 4);
      tickClock();
      eA = modelActive(0); eB = modelActive(1); eT = mTick[1];
      checks++;
      if ({tickA, activeA, anyA} !== {mTick[0], eA, |mTick[0]}) begin
        errors++;
        $display("[TB] FAIL random4 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickA, activeA, anyA, mTick[0], eA, |mTick[0]);
      end
      checks++;
      if ({tickB, activeB, anyB} !== {eT[2:0], eB[2:0], |eT}) begin
        errors++;
        $display("[TB] FAIL random3 cyc %0d: got %b/%b/%b want %b/%b/%b", i, tickB, activeB, anyB, eT[2:0], eB[2:0], |eT);
      end
    end
    reset_n = 1'b1;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_enable_gap();
    test_sync_restart();
    test_invalid_write();
    test_zero_div_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
